// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder for the rate-1/2, K=3 code (G0=111, G1=101).
// Consumes the serial code stream (c0 then c1 per symbol). It runs a 4-state
// add-compare-select with register-exchange survivors, emits each data bit
// TB_LEN-1 symbols late, and reports the best path metric increment.
module viterbi_decoder #(
   parameter int TB_LEN = 16,  // survivor depth in symbols, 4..64
   parameter int PM_W   = 6    // path metric width, >= 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            code_valid,
   input  logic            code_in,
   output logic            data_out,
   output logic            data_valid,
   output logic [PM_W-1:0] best_pm
);

   localparam int SUM_W = PM_W + 1;
   localparam int CNT_W = $clog2(TB_LEN + 1);

   // Handshake: code_in is consumed on every rising edge where code_valid=1.
   // There is no back-pressure. data_valid is a one-clock pulse that qualifies data_out.

   // Input pairing
   logic              phase_q;
   logic              c0_q;

   // Trellis state. The oldest survivor bit is consumed only at the moment
   // it is formed. It goes straight to data_out, so only TB_LEN-1 bits are kept.
   logic [PM_W-1:0]   pm_q   [4];
   logic [TB_LEN-2:0] surv_q [4];
   logic [CNT_W-1:0]  sym_cnt_q;

   // Registered outputs
   logic              data_out_q;
   logic              data_valid_q;
   logic [PM_W-1:0]   best_pm_q;

   // ACS datapath
   logic              step;
   logic [1:0]        nn;
   logic [1:0]        bm0    [4];
   logic [1:0]        bm1    [4];
   logic [SUM_W-1:0]  cand0  [4];
   logic [SUM_W-1:0]  cand1  [4];
   logic [3:0]        sel;
   logic [SUM_W-1:0]  new_raw[4];
   logic [SUM_W-1:0]  min_lo;
   logic [SUM_W-1:0]  min_hi;
   logic [SUM_W-1:0]  min_raw;
   logic [1:0]        best_idx;
   logic [PM_W-1:0]   pm_d   [4];
   logic [TB_LEN-1:0] surv_d [4];

   // Add-compare-select for all four states, then normalise and pick best state
   always_comb begin
      step     = code_valid & phase_q;
      nn       = '0;
      sel      = '0;
      best_idx = 2'd0;
      for (int n = 0; n < 4; n++) begin
         nn = 2'(n);
         // New state {a,b}: predecessor {x,a}, expected c0=b^a^x, c1=b^x
         bm0[n]     = 2'(c0_q ^ nn[1] ^ nn[0]) + 2'(code_in ^ nn[0]);
         bm1[n]     = 2'(c0_q ^ nn[1] ^ nn[0] ^ 1'b1) + 2'(code_in ^ nn[0] ^ 1'b1);
         cand0[n]   = SUM_W'(pm_q[{1'b0, nn[1]}]) + SUM_W'(bm0[n]);
         cand1[n]   = SUM_W'(pm_q[{1'b1, nn[1]}]) + SUM_W'(bm1[n]);
         // Ties resolve toward p0
         sel[n]     = (cand1[n] < cand0[n]);
         new_raw[n] = sel[n] ? cand1[n] : cand0[n];
         surv_d[n]  = {surv_q[{sel[n], nn[1]}], nn[0]};
      end
      min_lo  = (new_raw[1] < new_raw[0]) ? new_raw[1] : new_raw[0];
      min_hi  = (new_raw[3] < new_raw[2]) ? new_raw[3] : new_raw[2];
      min_raw = (min_hi < min_lo) ? min_hi : min_lo;
      // Later assignments win, so the lowest index holding the minimum is kept
      if (new_raw[3] == min_raw) best_idx = 2'd3;
      if (new_raw[2] == min_raw) best_idx = 2'd2;
      if (new_raw[1] == min_raw) best_idx = 2'd1;
      if (new_raw[0] == min_raw) best_idx = 2'd0;
      for (int n = 0; n < 4; n++) begin
         pm_d[n] = PM_W'(new_raw[n] - min_raw);
      end
   end

   // Bit pairing, metric/survivor update, symbol counting and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q      <= 1'b0;
         c0_q         <= 1'b0;
         sym_cnt_q    <= '0;
         data_out_q   <= 1'b0;
         data_valid_q <= 1'b0;
         best_pm_q    <= '0;
         for (int n = 0; n < 4; n++) begin
            pm_q[n]   <= (n == 0) ? '0 : PM_W'(4);
            surv_q[n] <= '0;
         end
      end else begin
         data_valid_q <= 1'b0;
         if (code_valid) begin
            phase_q <= ~phase_q;
            if (!phase_q) begin
               c0_q <= code_in;
            end
         end
         if (step) begin
            for (int n = 0; n < 4; n++) begin
               pm_q[n]   <= pm_d[n];
               surv_q[n] <= surv_d[n][TB_LEN-2:0];
            end
            best_pm_q <= PM_W'(min_raw);
            if (sym_cnt_q < CNT_W'(TB_LEN)) begin
               sym_cnt_q <= sym_cnt_q + 1'b1;
            end
            // This step is symbol number TB_LEN or later
            if (sym_cnt_q >= CNT_W'(TB_LEN - 1)) begin
               data_valid_q <= 1'b1;
               data_out_q   <= surv_d[best_idx][TB_LEN-1];
            end
         end
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign best_pm    = best_pm_q;

endmodule
